// File: rtl/store_buffer.sv
// Store buffer: in-order FIFO of stores that waits for base/data operands on the
// CDBs, reports resolved stores to the ROB, and writes committed stores to
// memory one at a time from the head.
module store_buffer #(
   parameter int unsigned SBSZ  = 16,
   parameter int unsigned ROBBW = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             inst_ID_flag,
   input  logic [1:0]       inst_ID_len,
   input  logic [ROBBW-1:0] inst_ID_rob_id,
   input  logic [31:0]      inst_ID_imm,
   input  logic             base_rdy,
   input  logic [31:0]      base_val,
   input  logic [ROBBW-1:0] base_tag,
   input  logic             data_rdy,
   input  logic [31:0]      data_val,
   input  logic [ROBBW-1:0] data_tag,
   input  logic             ex_cdb_flag,
   input  logic [ROBBW-1:0] ex_cdb_rob_id,
   input  logic [31:0]      ex_cdb_val,
   input  logic             ld_cdb_flag,
   input  logic [ROBBW-1:0] ld_cdb_rob_id,
   input  logic [31:0]      ld_cdb_val,
   output logic             SB_nex_ava,
   output logic             st_rdy_flag,
   output logic [ROBBW-1:0] st_rdy_rob_id,
   input  logic             ROB_cmt_st_flag,
   input  logic [ROBBW-1:0] ROB_cmt_st_rob_id,
   output logic             mem_st_flag,
   output logic [31:0]      mem_st_addr,
   output logic [31:0]      mem_st_data,
   output logic [1:0]       mem_st_len,
   input  logic             mem_st_done
);

   localparam int unsigned AW = $clog2(SBSZ);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {
      ST_FREE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RES  = 2'd2,
      ST_CMT  = 2'd3
   } ent_state_e;

   typedef struct packed {
      ent_state_e       st;
      logic [1:0]       len;
      logic [ROBBW-1:0] rob;
      logic [31:0]      imm;
      logic             bv;
      logic [31:0]      bval;
      logic [ROBBW-1:0] btag;
      logic             dv;
      logic [31:0]      dval;
      logic [ROBBW-1:0] dtag;
   } entry_t;

   entry_t           ent_q [SBSZ];
   entry_t           ent_d [SBSZ];
   logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic             st_rdy_flag_q, st_rdy_flag_d;
   logic [ROBBW-1:0] st_rdy_rob_id_q, st_rdy_rob_id_d;
   logic             mem_st_flag_q, mem_st_flag_d;
   logic [31:0]      mem_st_addr_q, mem_st_addr_d;
   logic [31:0]      mem_st_data_q, mem_st_data_d;
   logic [1:0]       mem_st_len_q, mem_st_len_d;

   logic             sel_found;
   logic [AW-1:0]    sel_idx;
   logic [AW-1:0]    scan_idx;
   logic             push, pop;
   logic             iss_bv, iss_dv;
   logic [31:0]      iss_bval, iss_dval;

   // Issue-time operand capture, including a same-cycle CDB broadcast
   always_comb begin
      iss_bv   = base_rdy;
      iss_bval = base_val;
      if (!base_rdy) begin
         if (ex_cdb_flag && ex_cdb_rob_id == base_tag) begin
            iss_bv   = 1'b1;
            iss_bval = ex_cdb_val;
         end else if (ld_cdb_flag && ld_cdb_rob_id == base_tag) begin
            iss_bv   = 1'b1;
            iss_bval = ld_cdb_val;
         end
      end
      iss_dv   = data_rdy;
      iss_dval = data_val;
      if (!data_rdy) begin
         if (ex_cdb_flag && ex_cdb_rob_id == data_tag) begin
            iss_dv   = 1'b1;
            iss_dval = ex_cdb_val;
         end else if (ld_cdb_flag && ld_cdb_rob_id == data_tag) begin
            iss_dv   = 1'b1;
            iss_dval = ld_cdb_val;
         end
      end
   end

   // Oldest-first search (from head) for a WAIT entry with both operands valid
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      scan_idx  = '0;
      for (int i = 0; i < int'(SBSZ); i++) begin
         scan_idx = head_q + AW'(i);
         if (!sel_found && ent_q[scan_idx].st == ST_WAIT &&
             ent_q[scan_idx].bv && ent_q[scan_idx].dv) begin
            sel_found = 1'b1;
            sel_idx   = scan_idx;
         end
      end
   end

   // Next-state: CDB snoop, resolve/report, commit, memory handshake, issue
   always_comb begin
      ent_d           = ent_q;
      head_d          = head_q;
      tail_d          = tail_q;
      count_d         = count_q;
      push            = 1'b0;
      pop             = 1'b0;
      st_rdy_flag_d   = 1'b0;
      st_rdy_rob_id_d = st_rdy_rob_id_q;
      mem_st_flag_d   = mem_st_flag_q;
      mem_st_addr_d   = mem_st_addr_q;
      mem_st_data_d   = mem_st_data_q;
      mem_st_len_d    = mem_st_len_q;

      if (rdy) begin
         for (int i = 0; i < int'(SBSZ); i++) begin
            if (ent_q[i].st == ST_WAIT) begin
               if (!ent_q[i].bv) begin
                  if (ex_cdb_flag && ex_cdb_rob_id == ent_q[i].btag) begin
                     ent_d[i].bv   = 1'b1;
                     ent_d[i].bval = ex_cdb_val;
                  end else if (ld_cdb_flag && ld_cdb_rob_id == ent_q[i].btag) begin
                     ent_d[i].bv   = 1'b1;
                     ent_d[i].bval = ld_cdb_val;
                  end
               end
               if (!ent_q[i].dv) begin
                  if (ex_cdb_flag && ex_cdb_rob_id == ent_q[i].dtag) begin
                     ent_d[i].dv   = 1'b1;
                     ent_d[i].dval = ex_cdb_val;
                  end else if (ld_cdb_flag && ld_cdb_rob_id == ent_q[i].dtag) begin
                     ent_d[i].dv   = 1'b1;
                     ent_d[i].dval = ld_cdb_val;
                  end
               end
            end
         end

         if (sel_found) begin
            ent_d[sel_idx].st = ST_RES;
            st_rdy_flag_d     = 1'b1;
            st_rdy_rob_id_d   = ent_q[sel_idx].rob;
         end

         if (ROB_cmt_st_flag) begin
            for (int i = 0; i < int'(SBSZ); i++) begin
               if (ent_q[i].st == ST_RES && ent_q[i].rob == ROB_cmt_st_rob_id) begin
                  ent_d[i].st = ST_CMT;
               end
            end
         end

         // A done edge only retires; the next request waits one cycle
         if (mem_st_flag_q) begin
            if (mem_st_done) begin
               mem_st_flag_d     = 1'b0;
               ent_d[head_q].st  = ST_FREE;
               head_d            = head_q + AW'(1);
               pop               = 1'b1;
            end
         end else if (ent_q[head_q].st == ST_CMT) begin
            mem_st_flag_d = 1'b1;
            mem_st_addr_d = ent_q[head_q].bval + ent_q[head_q].imm;
            mem_st_data_d = ent_q[head_q].dval;
            mem_st_len_d  = ent_q[head_q].len;
         end

         if (inst_ID_flag && count_q < CW'(SBSZ)) begin
            ent_d[tail_q] = '{st:   ST_WAIT,
                              len:  inst_ID_len,
                              rob:  inst_ID_rob_id,
                              imm:  inst_ID_imm,
                              bv:   iss_bv,
                              bval: iss_bval,
                              btag: base_tag,
                              dv:   iss_dv,
                              dval: iss_dval,
                              dtag: data_tag};
            tail_d = tail_q + AW'(1);
            push   = 1'b1;
         end

         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(SBSZ); i++) begin
            ent_q[i] <= '0;
         end
         head_q          <= '0;
         tail_q          <= '0;
         count_q         <= '0;
         st_rdy_flag_q   <= 1'b0;
         st_rdy_rob_id_q <= '0;
         mem_st_flag_q   <= 1'b0;
         mem_st_addr_q   <= '0;
         mem_st_data_q   <= '0;
         mem_st_len_q    <= '0;
      end else begin
         ent_q           <= ent_d;
         head_q          <= head_d;
         tail_q          <= tail_d;
         count_q         <= count_d;
         st_rdy_flag_q   <= st_rdy_flag_d;
         st_rdy_rob_id_q <= st_rdy_rob_id_d;
         mem_st_flag_q   <= mem_st_flag_d;
         mem_st_addr_q   <= mem_st_addr_d;
         mem_st_data_q   <= mem_st_data_d;
         mem_st_len_q    <= mem_st_len_d;
      end
   end

   // Space advertisement for the issue stage
   assign SB_nex_ava = (count_q <= CW'(SBSZ - 2)) ||
                       ((count_q == CW'(SBSZ - 1)) && !inst_ID_flag);

   assign st_rdy_flag   = st_rdy_flag_q;
   assign st_rdy_rob_id = st_rdy_rob_id_q;
   assign mem_st_flag   = mem_st_flag_q;
   assign mem_st_addr   = mem_st_addr_q;
   assign mem_st_data   = mem_st_data_q;
   assign mem_st_len    = mem_st_len_q;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with hand-computed expectations.
module tb_store_buffer;

   localparam int SBSZ  = 16;
   localparam int ROBBW = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             rdy;
   logic             inst_ID_flag;
   logic [1:0]       inst_ID_len;
   logic [ROBBW-1:0] inst_ID_rob_id;
   logic [31:0]      inst_ID_imm;
   logic             base_rdy;
   logic [31:0]      base_val;
   logic [ROBBW-1:0] base_tag;
   logic             data_rdy;
   logic [31:0]      data_val;
   logic [ROBBW-1:0] data_tag;
   logic             ex_cdb_flag;
   logic [ROBBW-1:0] ex_cdb_rob_id;
   logic [31:0]      ex_cdb_val;
   logic             ld_cdb_flag;
   logic [ROBBW-1:0] ld_cdb_rob_id;
   logic [31:0]      ld_cdb_val;
   logic             SB_nex_ava;
   logic             st_rdy_flag;
   logic [ROBBW-1:0] st_rdy_rob_id;
   logic             ROB_cmt_st_flag;
   logic [ROBBW-1:0] ROB_cmt_st_rob_id;
   logic             mem_st_flag;
   logic [31:0]      mem_st_addr;
   logic [31:0]      mem_st_data;
   logic [1:0]       mem_st_len;
   logic             mem_st_done;

   int n_vec = 0;
   int n_err = 0;

   store_buffer #(.SBSZ(SBSZ), .ROBBW(ROBBW)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .inst_ID_flag(inst_ID_flag), .inst_ID_len(inst_ID_len),
      .inst_ID_rob_id(inst_ID_rob_id), .inst_ID_imm(inst_ID_imm),
      .base_rdy(base_rdy), .base_val(base_val), .base_tag(base_tag),
      .data_rdy(data_rdy), .data_val(data_val), .data_tag(data_tag),
      .ex_cdb_flag(ex_cdb_flag), .ex_cdb_rob_id(ex_cdb_rob_id), .ex_cdb_val(ex_cdb_val),
      .ld_cdb_flag(ld_cdb_flag), .ld_cdb_rob_id(ld_cdb_rob_id), .ld_cdb_val(ld_cdb_val),
      .SB_nex_ava(SB_nex_ava), .st_rdy_flag(st_rdy_flag), .st_rdy_rob_id(st_rdy_rob_id),
      .ROB_cmt_st_flag(ROB_cmt_st_flag), .ROB_cmt_st_rob_id(ROB_cmt_st_rob_id),
      .mem_st_flag(mem_st_flag), .mem_st_addr(mem_st_addr), .mem_st_data(mem_st_data),
      .mem_st_len(mem_st_len), .mem_st_done(mem_st_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      inst_ID_flag = 1'b0; inst_ID_len = 2'b00; inst_ID_rob_id = '0; inst_ID_imm = '0;
      base_rdy = 1'b0; base_val = '0; base_tag = '0;
      data_rdy = 1'b0; data_val = '0; data_tag = '0;
      ex_cdb_flag = 1'b0; ex_cdb_rob_id = '0; ex_cdb_val = '0;
      ld_cdb_flag = 1'b0; ld_cdb_rob_id = '0; ld_cdb_val = '0;
      ROB_cmt_st_flag = 1'b0; ROB_cmt_st_rob_id = '0;
      mem_st_done = 1'b0;
   endtask

   task automatic issue(input logic [3:0] rob, input logic brdy, input logic [31:0] base,
                        input logic [3:0] btag, input logic [31:0] imm, input logic drdy,
                        input logic [31:0] data, input logic [3:0] dtag, input logic [1:0] len);
      inst_ID_flag = 1'b1; inst_ID_rob_id = rob; inst_ID_imm = imm; inst_ID_len = len;
      base_rdy = brdy; base_val = base; base_tag = btag;
      data_rdy = drdy; data_val = data; data_tag = dtag;
   endtask

   // Commit a resolved head store and retire it through the memory handshake
   task automatic drain(input string tag, input logic [3:0] rob, input logic [31:0] addr,
                        input logic [31:0] data, input logic [1:0] len);
      ROB_cmt_st_flag = 1'b1; ROB_cmt_st_rob_id = rob;
      tick();
      ROB_cmt_st_flag = 1'b0;
      tick();
      check({tag, "_flag"}, 32'(mem_st_flag), 32'd1);
      check({tag, "_addr"}, mem_st_addr, addr);
      check({tag, "_data"}, mem_st_data, data);
      check({tag, "_len"},  32'(mem_st_len), 32'(len));
      mem_st_done = 1'b1;
      tick();
      mem_st_done = 1'b0;
      check({tag, "_done"}, 32'(mem_st_flag), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      idle();
      rdy = 1'b1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ava",     32'(SB_nex_ava), 32'd1);
      check("rst_strdy",   32'(st_rdy_flag), 32'd0);
      check("rst_memflag", 32'(mem_st_flag), 32'd0);
      check("rst_count",   32'(dut.count_q), 32'd0);
      rst = 1'b1;
      tick();

      // Basic store: both operands ready
      issue(4'd3, 1'b1, 32'h1000, 4'd0, 32'd4, 1'b1, 32'hAB, 4'd0, 2'b10);
      tick();
      idle();
      check("b_strdy_early", 32'(st_rdy_flag), 32'd0);
      tick();
      check("b_strdy", 32'(st_rdy_flag), 32'd1);
      check("b_robid", 32'(st_rdy_rob_id), 32'd3);
      tick();
      check("b_strdy_pulse", 32'(st_rdy_flag), 32'd0);
      drain("b", 4'd3, 32'h1004, 32'hAB, 2'b10);
      check("b_count", 32'(dut.count_q), 32'd0);

      // Base pending, woken by ALU broadcast
      issue(4'd5, 1'b0, 32'h0, 4'd2, 32'd8, 1'b1, 32'h77, 4'd0, 2'b00);
      tick();
      idle();
      tick();
      check("ex_wait", 32'(st_rdy_flag), 32'd0);
      ex_cdb_flag = 1'b1; ex_cdb_rob_id = 4'd2; ex_cdb_val = 32'h20;
      tick();
      idle();
      check("ex_bcast", 32'(st_rdy_flag), 32'd0);
      tick();
      check("ex_strdy", 32'(st_rdy_flag), 32'd1);
      check("ex_robid", 32'(st_rdy_rob_id), 32'd5);
      tick();
      drain("ex", 4'd5, 32'h28, 32'h77, 2'b00);

      // Data captured from a load broadcast in the issue cycle
      issue(4'd7, 1'b1, 32'h2000, 4'd0, 32'd0, 1'b0, 32'h0, 4'd6, 2'b01);
      ld_cdb_flag = 1'b1; ld_cdb_rob_id = 4'd6; ld_cdb_val = 32'h55;
      tick();
      idle();
      tick();
      check("ld_strdy", 32'(st_rdy_flag), 32'd1);
      check("ld_robid", 32'(st_rdy_rob_id), 32'd7);
      tick();
      drain("ld", 4'd7, 32'h2000, 32'h55, 2'b01);

      // Non-matching broadcast is ignored; matching load broadcast wakes it
      issue(4'd9, 1'b0, 32'h0, 4'd4, 32'h10, 1'b1, 32'h99, 4'd0, 2'b01);
      tick();
      idle();
      ex_cdb_flag = 1'b1; ex_cdb_rob_id = 4'd5; ex_cdb_val = 32'h123;
      tick();
      idle();
      tick();
      check("nm_wait", 32'(st_rdy_flag), 32'd0);
      ld_cdb_flag = 1'b1; ld_cdb_rob_id = 4'd4; ld_cdb_val = 32'h40;
      tick();
      idle();
      tick();
      check("nm_strdy", 32'(st_rdy_flag), 32'd1);
      check("nm_robid", 32'(st_rdy_rob_id), 32'd9);
      tick();
      drain("nm", 4'd9, 32'h50, 32'h99, 2'b01);

      // rdy low freezes resolution
      issue(4'd6, 1'b1, 32'h600, 4'd0, 32'd0, 1'b1, 32'h66, 4'd0, 2'b00);
      tick();
      idle();
      rdy = 1'b0;
      tick();
      check("frz_1", 32'(st_rdy_flag), 32'd0);
      tick();
      check("frz_2", 32'(st_rdy_flag), 32'd0);
      rdy = 1'b1;
      tick();
      check("frz_strdy", 32'(st_rdy_flag), 32'd1);
      check("frz_robid", 32'(st_rdy_rob_id), 32'd6);
      tick();
      check("frz_pulse", 32'(st_rdy_flag), 32'd0);
      drain("frz", 4'd6, 32'h600, 32'h66, 2'b00);

      // Fill to SBSZ-1, then full, then ignored issue, then pop+issue
      for (int i = 0; i < SBSZ - 1; i++) begin
         issue(4'(i), 1'b1, 32'(i) << 8, 4'd0, 32'd0, 1'b1, 32'(i), 4'd0, 2'b10);
         tick();
      end
      idle();
      #1;
      check("f15_count", 32'(dut.count_q), 32'd15);
      check("f15_ava_idle", 32'(SB_nex_ava), 32'd1);
      issue(4'd15, 1'b1, 32'hF00, 4'd0, 32'd0, 1'b1, 32'd15, 4'd0, 2'b10);
      #1;
      check("f15_ava_iss", 32'(SB_nex_ava), 32'd0);
      tick();
      idle();
      check("f16_count", 32'(dut.count_q), 32'd16);
      check("f16_ava", 32'(SB_nex_ava), 32'd0);
      issue(4'd9, 1'b1, 32'hBAD0, 4'd0, 32'd0, 1'b1, 32'hDEAD, 4'd0, 2'b10);
      tick();
      idle();
      check("full_ignored", 32'(dut.count_q), 32'd16);
      repeat (3) tick();
      drain("f_e0", 4'd0, 32'h0, 32'h0, 2'b10);
      ROB_cmt_st_flag = 1'b1; ROB_cmt_st_rob_id = 4'd1;
      tick();
      ROB_cmt_st_flag = 1'b0;
      tick();
      check("f_e1_flag", 32'(mem_st_flag), 32'd1);
      check("f_e1_addr", mem_st_addr, 32'h100);
      mem_st_done = 1'b1;
      issue(4'd0, 1'b1, 32'h3000, 4'd0, 32'd0, 1'b1, 32'h99, 4'd0, 2'b10);
      tick();
      idle();
      check("popiss_count", 32'(dut.count_q), 32'd15);
      check("popiss_flag", 32'(mem_st_flag), 32'd0);
      tick();
      for (int j = 2; j < SBSZ; j++) begin
         drain($sformatf("f_e%0d", j), 4'(j), 32'(j) << 8, 32'(j), 2'b10);
      end
      drain("f_new", 4'd0, 32'h3000, 32'h99, 2'b10);
      check("f_empty", 32'(dut.count_q), 32'd0);

      // Two commits; memory done held off; one-cycle gap between requests
      issue(4'd1, 1'b1, 32'h4000, 4'd0, 32'd0, 1'b1, 32'h11, 4'd0, 2'b10);
      tick();
      issue(4'd2, 1'b1, 32'h5000, 4'd0, 32'd0, 1'b1, 32'h22, 4'd0, 2'b01);
      tick();
      idle();
      repeat (2) tick();
      ROB_cmt_st_flag = 1'b1; ROB_cmt_st_rob_id = 4'd1;
      tick();
      ROB_cmt_st_rob_id = 4'd2;
      tick();
      idle();
      check("hold_flag0", 32'(mem_st_flag), 32'd1);
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("hold_flag%0d", k + 1), 32'(mem_st_flag), 32'd1);
         check($sformatf("hold_addr%0d", k + 1), mem_st_addr, 32'h4000);
         check($sformatf("hold_data%0d", k + 1), mem_st_data, 32'h11);
         check($sformatf("hold_len%0d", k + 1), 32'(mem_st_len), 32'd2);
      end
      mem_st_done = 1'b1;
      tick();
      mem_st_done = 1'b0;
      check("gap_flag", 32'(mem_st_flag), 32'd0);
      tick();
      check("req2_flag", 32'(mem_st_flag), 32'd1);
      check("req2_addr", mem_st_addr, 32'h5000);
      check("req2_data", mem_st_data, 32'h22);
      check("req2_len", 32'(mem_st_len), 32'd1);
      mem_st_done = 1'b1;
      tick();
      mem_st_done = 1'b0;
      check("req2_done", 32'(mem_st_flag), 32'd0);
      check("req2_count", 32'(dut.count_q), 32'd0);

      // Reset in the middle of a memory request
      issue(4'd4, 1'b1, 32'h700, 4'd0, 32'd0, 1'b1, 32'h44, 4'd0, 2'b10);
      tick();
      idle();
      tick();
      ROB_cmt_st_flag = 1'b1; ROB_cmt_st_rob_id = 4'd4;
      tick();
      ROB_cmt_st_flag = 1'b0;
      tick();
      check("mr_flag", 32'(mem_st_flag), 32'd1);
      rst = 1'b0;
      #1;
      check("mr_rst_flag", 32'(mem_st_flag), 32'd0);
      check("mr_rst_addr", mem_st_addr, 32'd0);
      check("mr_rst_data", mem_st_data, 32'd0);
      check("mr_rst_len", 32'(mem_st_len), 32'd0);
      check("mr_rst_count", 32'(dut.count_q), 32'd0);
      check("mr_rst_ava", 32'(SB_nex_ava), 32'd1);
      #2;
      rst = 1'b1;
      tick();
      mem_st_done = 1'b1;
      tick();
      mem_st_done = 1'b0;
      check("mr_late_flag", 32'(mem_st_flag), 32'd0);
      check("mr_late_count", 32'(dut.count_q), 32'd0);
      tick();
      check("mr_late_flag2", 32'(mem_st_flag), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter SBSZ, default 16, store-buffer depth in entries (power of two, at least 4).
REQ-002 SHALL have parameter ROBBW, default 4, reorder-buffer id width.
REQ-003 SHALL have ports, one per line, with name, direction, width and meaning:
 clk  in  1  clock, rising edge.
 rst  in  1  asynchronous, active-low reset.
 rdy  in  1  global enable; when low, all state holds.
 inst_ID_flag  in  1  store issue valid.
 inst_ID_len  in  2  store width: 00 byte, 01 half, 10 word.
 inst_ID_rob_id  in  ROBBW  ROB id of the store.
 inst_ID_imm  in  32  sign-extended offset.
 base_rdy  in  1  base value valid.
 base_val  in  32  base value.
 base_tag  in  ROBBW  producer ROB id of the base when base_rdy is low.
 data_rdy  in  1  data value valid.
 data_val  in  32  data value.
 data_tag  in  ROBBW  producer ROB id of the data when data_rdy is low.
 ex_cdb_flag  in  1  ALU broadcast valid.
 ex_cdb_rob_id  in  ROBBW  ALU broadcast tag.
 ex_cdb_val  in  32  ALU broadcast value.
 ld_cdb_flag  in  1  load broadcast valid.
 ld_cdb_rob_id  in  ROBBW  load broadcast tag.
 ld_cdb_val  in  32  load broadcast value.
 SB_nex_ava  out  1  buffer can accept an issue next cycle.
 st_rdy_flag  out  1  one-cycle pulse: store address and data resolved.
 st_rdy_rob_id  out  ROBBW  ROB id reported.
 ROB_cmt_st_flag  in  1  ROB commits a store.
 ROB_cmt_st_rob_id  in  ROBBW  ROB id committed.
 mem_st_flag  out  1  memory write request.
 mem_st_addr  out  32  byte address.
 mem_st_data  out  32  data, low bytes significant.
 mem_st_len  out  2  copy of inst_ID_len.
 mem_st_done  in  1  one-cycle pulse from memory: write finished.

Function
REQ-004 SHALL hold entries in a circular FIFO with head, tail and count; index wraps modulo SBSZ.
REQ-005 SHALL give each entry the states FREE, WAIT (an operand is pending), RES (resolved, reported) and CMT (committed).
REQ-006 SHALL, on inst_ID_flag with count<SBSZ, write the entry at tail, capture the operands and tags, advance tail and increment count.
REQ-007 SHALL ignore an issue when count==SBSZ, leaving state unchanged.
REQ-008 SHALL capture a pending operand from either CDB when the CDB tag matches, including a broadcast in the same cycle as the issue.
REQ-009 SHALL compute the address as base+imm, modulo 2^32, once both operands are valid.
REQ-010 SHALL, each cycle, take the oldest WAIT entry whose operands are both valid, move it to RES, and pulse st_rdy_flag with its rob_id on the next cycle.
REQ-011 SHALL report at most one entry per cycle, so the earliest report is one cycle after issue with both operands ready.
REQ-012 SHALL move the RES entry whose rob_id matches ROB_cmt_st_rob_id to CMT when ROB_cmt_st_flag is high.
REQ-013 SHALL ignore a commit that matches no RES entry.
REQ-014 SHALL, when the head entry is CMT and no request is outstanding, assert mem_st_flag with addr, data and len registered from that entry.
REQ-015 SHALL hold mem_st_flag, mem_st_addr, mem_st_data and mem_st_len stable until mem_st_done.
REQ-016 SHALL, on mem_st_done, clear mem_st_flag at that edge, free the head entry, advance head and decrement count.
REQ-017 SHALL not start a new request in the same cycle as mem_st_done, so back-to-back requests have a one-cycle gap.
REQ-018 SHALL, on a simultaneous issue and pop, change count by net zero.
REQ-019 SHALL drive SB_nex_ava combinationally: high when count<=SBSZ-2, or when count==SBSZ-1 and inst_ID_flag is low.
REQ-020 SHALL ignore mem_st_done when no request is outstanding.
REQ-021 SHALL, with rdy low, freeze all registers; outputs hold, but st_rdy_flag is not re-pulsed.

Reset
REQ-022 SHALL, on rst low, asynchronously set all entries to FREE, head, tail and count to 0, and st_rdy_flag, st_rdy_rob_id, mem_st_flag, mem_st_addr, mem_st_data and mem_st_len to 0.
REQ-023 SHALL abandon a mid-flight memory request on reset; mem_st_flag drops immediately and a later mem_st_done is ignored.
REQ-024 SHALL have SB_nex_ava=1 after reset.

Verification
REQ-025 SHALL pass: issue rob 3, base 0x1000, imm 4, data 0xAB, both ready -> next cycle st_rdy_flag=1, st_rdy_rob_id=3; commit 3 -> mem_st_flag=1, addr 0x1004, data 0xAB; done -> flag 0, count 0.
REQ-026 SHALL pass: issue rob 5 with base pending on tag 2; ex_cdb rob 2, value 0x20 -> st_rdy for 5 the cycle after the broadcast, address 0x20+imm.
REQ-027 SHALL pass: issue rob 7 with data tag 6 while ld_cdb broadcasts tag 6, value 0x55, the same cycle -> captured; st_rdy next cycle, data 0x55.
REQ-028 SHALL pass: fill to SBSZ-1 -> SB_nex_ava=1 only while inst_ID_flag=0; at SBSZ, an issue is ignored; pop and issue in one cycle -> count unchanged.
REQ-029 SHALL pass: commit order 1,2 with mem_st_done held off 3 cycles -> request fields stable; second request starts 2 cycles after the first done.
REQ-030 SHALL pass: rst low while mem_st_flag=1 -> all outputs 0 at once, count 0, and a later mem_st_done causes no change.
